// File: rtl/fp_fxp_bitserial_mul.sv
// Bit-serial fixed-point x floating-point multiplier: emits one scaled copy of the
// float operand per set bit of the fixed-point operand, skipping zero bits.
module fp_fxp_bitserial_mul #(
  parameter int FXP_WIDTH     = 4,
  parameter int FP_WIDTH      = 32,
  parameter int FP_FRAC_WIDTH = 23,
  parameter int FP_EXP_WIDTH  = FP_WIDTH - FP_FRAC_WIDTH - 1,
  parameter int SCALE_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FXP_WIDTH-1:0]   in_a,
  input  logic                   in_a_signed,
  input  logic [SCALE_WIDTH-1:0] in_a_scale,
  input  logic [FP_WIDTH-1:0]    in_b,
  input  logic                   in_b_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FP_WIDTH-1:0]    out_data,
  output logic                   out_last
);

  localparam int EW2 = FP_EXP_WIDTH + 2;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [FXP_WIDTH-1:0]     r_mask;
  logic                     r_signed;
  logic [SCALE_WIDTH-1:0]   r_scale;
  logic [FP_WIDTH-1:0]      r_b;
  logic                     r_bzero;
  logic [FP_WIDTH-1:0]      r_data;
  logic                     r_last;
  logic                     w_accept;
  logic                     w_fire;
  logic [FXP_WIDTH-1:0]     w_low;
  logic [FXP_WIDTH-1:0]     w_mask_nxt;
  logic [FP_WIDTH:0]        w_beat_first;
  logic [FP_WIDTH:0]        w_beat_nxt;

  // Beat for the lowest set bit of m, returned as {last, data}.
  function automatic logic [FP_WIDTH:0] f_beat(
    input logic [FXP_WIDTH-1:0]   m,
    input logic                   a_sgn,
    input logic [SCALE_WIDTH-1:0] sc,
    input logic [FP_WIDTH-1:0]    b,
    input logic                   b_zero
  );
    logic [FXP_WIDTH-1:0]     low;
    logic [EW2-1:0]           idx;
    logic [EW2-1:0]           e;
    logic [FP_EXP_WIDTH-1:0]  b_exp;
    logic [FP_FRAC_WIDTH-1:0] b_frac;
    logic                     sgn;
    logic                     last;
    logic [FP_WIDTH-1:0]      d;
    b_exp  = b[FP_WIDTH-2 -: FP_EXP_WIDTH];
    b_frac = b[FP_FRAC_WIDTH-1:0];
    low    = m & (~m + FXP_WIDTH'(1'b1));
    idx    = '0;
    for (int k = 0; k < FXP_WIDTH; k++) begin
      idx = low[k] ? EW2'(k) : idx;
    end
    e    = EW2'(b_exp) + EW2'(sc) + idx;
    sgn  = b[FP_WIDTH-1] ^ (a_sgn & low[FXP_WIDTH-1]);
    last = ((m & ~low) == '0);
    if ((m == '0) || b_zero || (b_exp == '0)) begin
      d    = '0;
      last = 1'b1;
    end else if (b_exp == '1) begin
      d = {sgn, b[FP_WIDTH-2:0]};
    end else if (e >= EW2'({FP_EXP_WIDTH{1'b1}})) begin
      d = {sgn, {(FP_EXP_WIDTH-1){1'b1}}, 1'b0, {FP_FRAC_WIDTH{1'b1}}};
    end else begin
      d = {sgn, e[FP_EXP_WIDTH-1:0], b_frac};
    end
    return {last, d};
  endfunction

  assign w_accept     = in_valid & in_ready;
  assign w_fire       = out_valid & out_ready;
  assign w_low        = r_mask & (~r_mask + FXP_WIDTH'(1'b1));
  assign w_mask_nxt   = r_mask & ~w_low;
  assign w_beat_first = f_beat(in_a, in_a_signed, in_a_scale, in_b, in_b_zero);
  assign w_beat_nxt   = f_beat(w_mask_nxt, r_signed, r_scale, r_b, r_bzero);
  assign out_data     = r_data;
  assign out_last     = r_last;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = EMIT;
        end else begin
          w_next = IDLE;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && r_last) begin
          w_next = IDLE;
        end else begin
          w_next = EMIT;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture and beat register; the beat is precomputed so outputs come from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask   <= '0;
      r_signed <= 1'b0;
      r_scale  <= '0;
      r_b      <= '0;
      r_bzero  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
    end else if (w_accept) begin
      r_mask           <= in_a;
      r_signed         <= in_a_signed;
      r_scale          <= in_a_scale;
      r_b              <= in_b;
      r_bzero          <= in_b_zero;
      {r_last, r_data} <= w_beat_first;
    end else if (w_fire) begin
      r_mask <= w_mask_nxt;
      if (r_last) begin
        {r_last, r_data} <= '0;
      end else begin
        {r_last, r_data} <= w_beat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fp_fxp_bitserial_mul.sv
// Scoreboard bench: a driver pushes expected beats from an arithmetic reference model,
// a monitor pops and compares on every output handshake and checks stall stability.
module tb_fp_fxp_bitserial_mul;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic        in_a_signed;
  logic [3:0]  in_a_scale;
  logic [31:0] in_b;
  logic        in_b_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;
  logic [32:0] exp_q[$];

  fp_fxp_bitserial_mul dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_a_signed(in_a_signed), .in_a_scale(in_a_scale),
    .in_b(in_b), .in_b_zero(in_b_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Reference: b * 2^(i+scale) for each set bit i, as plain integer exponent arithmetic.
  task automatic model(input logic [3:0] a, input logic sg, input logic [3:0] sc,
                       input logic [31:0] b, input logic bz);
    int bexp;
    int e;
    int hi;
    logic s;
    logic [31:0] d;
    logic [7:0] ev;
    bexp = int'(b[30:23]);
    if (a == 4'd0 || bz || bexp == 0) begin
      exp_q.push_back({1'b1, 32'h0000_0000});
    end else begin
      hi = 0;
      for (int i = 0; i < 4; i++) if (a[i]) hi = i;
      for (int i = 0; i < 4; i++) begin
        if (a[i]) begin
          s = b[31] ^ (sg && i == 3);
          e = bexp + int'(sc) + i;
          if (bexp == 255) d = {s, b[30:0]};
          else if (e >= 255) d = {s, 8'hFE, 23'h7FFFFF};
          else begin
            ev = 8'(e);
            d = {s, ev, b[22:0]};
          end
          exp_q.push_back({(i == hi), d});
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [3:0] a, input logic sg, input logic [3:0] sc,
                      input logic [31:0] b, input logic bz);
    int n;
    in_valid = 1'b1; in_a = a; in_a_signed = sg; in_a_scale = sc; in_b = b; in_b_zero = bz;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(n), 64'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      model(a, sg, sc, b, bz);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("first_beat_latency", 64'(out_valid), 64'(1));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // out_ready driver: 0 always high, 1 toggling, 2 random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares each handshaked beat and checks stability while stalled.
  logic        hold_v = 1'b0;
  logic [32:0] hold_d;
  logic [32:0] exp_beat;
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else if (out_valid) begin
      if (hold_v) check("stall_hold", {31'd0, out_last, out_data}, {31'd0, hold_d});
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {31'd0, out_last, out_data}, 64'd0);
          if (!out_last && out_data == 32'd0) begin
            errors++;
            $display("FAIL unexpected_beat: got data 0 last 0 expected no beat");
          end
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", {31'd0, out_last, out_data}, {31'd0, exp_beat});
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_d = {out_last, out_data};
      end
    end else if (hold_v) begin
      check("valid_dropped_while_stalled", 64'(out_valid), 64'(1));
      hold_v = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    int          r;
    reset = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_a_signed = 1'b0;
    in_a_scale = 4'd0; in_b = 32'd0; in_b_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_last", 64'(out_last), 64'(0));
    check("reset_out_data", 64'(out_data), 64'(0));
    @(posedge clk); #1;

    // Unsigned two-beat case, then signed, saturation.
    rmode = 0;
    send(4'b0101, 1'b0, 4'd0, 32'h3F80_0000, 1'b0);
    wait_drain();
    send(4'b1000, 1'b1, 4'd1, 32'h3F80_0000, 1'b0);
    wait_drain();
    send(4'b0001, 1'b0, 4'd1, 32'h7F00_0000, 1'b0);
    wait_drain();

    // Zero operands: single zero beat, in_ready low in handshake cycle then high.
    send(4'b0000, 1'b0, 4'd0, 32'h3F80_0000, 1'b0);
    @(negedge clk);
    check("zero_in_ready_busy", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("zero_in_ready_back", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    send(4'b0110, 1'b0, 4'd0, 32'h3F80_0000, 1'b1);
    wait_drain();
    send(4'b1111, 1'b1, 4'd2, 32'hFF80_0000, 1'b0);
    wait_drain();

    // Backpressure with toggling out_ready.
    rmode = 1;
    send(4'b1111, 1'b0, 4'd0, 32'h3F80_0000, 1'b0);
    wait_drain();

    // Reset after the second beat: remaining beats must never appear.
    rmode = 0;
    send(4'b1111, 1'b0, 4'd0, 32'h3F80_0000, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_beats_left", 64'(exp_q.size()), 64'(2));
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    repeat (4) @(posedge clk);
    #1;

    // Randomized operands and backpressure.
    for (int t = 0; t < 300; t++) begin
      rmode = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      b = $urandom;
      if (r == 0) b[30:23] = 8'd0;
      else if (r == 1) b[30:23] = 8'd255;
      else if (r == 2) b[30:23] = 8'(250 + $urandom_range(0, 4));
      else b[30:23] = 8'($urandom_range(1, 254));
      send(4'($urandom), 1'($urandom), 4'($urandom), b, ($urandom_range(0, 9) == 0));
    end
    rmode = 0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_fxp_bitserial_mul.md
FP_FXP_BITSERIAL_MUL -- requirements
Module: fp_fxp_bitserial_mul

Interface
REQ-001 SHALL have parameter FXP_WIDTH, default 4, meaning fixed-point operand width in bits.
REQ-002 SHALL have parameter FP_WIDTH, default 32, meaning float word width.
REQ-003 SHALL have parameter FP_FRAC_WIDTH, default 23, meaning mantissa width.
REQ-004 SHALL have parameter FP_EXP_WIDTH, default FP_WIDTH-FP_FRAC_WIDTH-1, meaning exponent width.
REQ-005 SHALL have parameter SCALE_WIDTH, default 4, meaning exponent-scale input width.
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  operand pair valid.
REQ-009 in_ready  output  1  block accepts operands.
REQ-010 in_a  input  FXP_WIDTH  fixed-point operand.
REQ-011 in_a_signed  input  1  1: in_a two's complement; 0: unsigned.
REQ-012 in_a_scale  input  SCALE_WIDTH  unsigned exponent offset added to every partial product.
REQ-013 in_b  input  FP_WIDTH  float operand {sign, exp, frac}.
REQ-014 in_b_zero  input  1  forces in_b to be treated as zero.
REQ-015 out_valid  output  1  partial product valid.
REQ-016 out_ready  input  1  consumer accepts partial product.
REQ-017 out_data  output  FP_WIDTH  partial product b*2^(i+scale), sign-adjusted.
REQ-018 out_last  output  1  final beat for current operand pair.

Function
REQ-019 SHALL accept operands on in_valid && in_ready, registering in_a, in_a_signed, in_a_scale, in_b, in_b_zero.
REQ-020 SHALL implement states IDLE (in_ready=1, out_valid=0), EMIT (in_ready=0, out_valid=1); no other states.
REQ-021 IDLE->EMIT on accept; EMIT->IDLE on handshake (out_valid && out_ready) of a beat with out_last=1.
REQ-022 SHALL emit first beat in the cycle after accept (latency 1); one beat per cycle under out_ready=1.
REQ-023 SHALL emit one beat per set bit of registered in_a, lowest index first (zero-skipping priority encoder); bit cleared on its handshake.
REQ-024 out_last SHALL be 1 when the beat's bit is the highest remaining set bit.
REQ-025 Beat for bit i: frac = b_frac; exp = b_exp + in_a_scale + i computed in FP_EXP_WIDTH+2 bits; sign = b_s XOR (in_a_signed && i==FXP_WIDTH-1).
REQ-026 If computed exp >= 2^FP_EXP_WIDTH-1, beat SHALL saturate to max finite magnitude: exp = 2^FP_EXP_WIDTH-2, frac all ones, sign per REQ-025.
REQ-027 Operand pair is zero when in_a==0, in_b_zero==1, or b_exp==0; SHALL then emit exactly one beat out_data=0, out_last=1.
REQ-028 While out_valid && !out_ready, out_data and out_last SHALL hold stable.
REQ-029 in_ready SHALL be 0 in the cycle of the last-beat handshake; new accept possible no earlier than the next cycle.
REQ-030 in_b with b_exp all ones (Inf/NaN) SHALL pass through unchanged per beat, sign per REQ-025, no exponent addition.

Reset
REQ-031 reset SHALL force IDLE; in_ready=1, out_valid=0, out_last=0, out_data=0 on the following cycle.
REQ-032 reset mid-EMIT SHALL discard remaining beats; no beat of the aborted pair appears after reset.
REQ-033 reset SHALL take priority over simultaneous in_valid or out_ready.

Verification
REQ-034 Unsigned: in_a=4'b0101, scale=0, in_b=0x3F800000, out_ready=1 -> beats 0x3F800000 (last=0), 0x40800000 (last=1) on cycles 1,2 after accept.
REQ-035 Signed: in_a=4'b1000, signed=1, scale=1, in_b=0x3F800000 -> single beat 0xC1800000, last=1.
REQ-036 Saturation: in_a=4'b0001, scale=1, in_b=0x7F000000 -> single beat 0x7F7FFFFF, last=1.
REQ-037 Zero: in_a=0 (or in_b_zero=1) with in_b=0x3F800000 -> single beat 0x00000000, last=1; in_ready returns 1 next cycle.
REQ-038 Backpressure: in_a=4'b1111, out_ready toggled 0/1 each cycle -> four beats exps +0..+3, each held stable while stalled, last only on fourth.
REQ-039 Reset mid-EMIT: in_a=4'b1111, assert reset after second beat -> no further beats, in_ready=1, out_valid=0 next cycle.
